// File: rtl/rev_adder_pkg.sv
// Shared types for the Peres-gate adder uncompute engine: FSM states,
// index-width helper and the per-stage inverse result.
package rev_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic b;
    logic cin;
    logic anc;
  } stage_res_t;

  // Bits needed to index WIDTH lines; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reversible_full_adder_inv.sv
// Combinational inverse of one Peres-gate adder stage: (a, p, s, c) -> (b, cin, anc).
// The ancilla is only computed when REV_ADDER_ANC_CHECK_EN is defined.
module reversible_full_adder_inv
  import rev_adder_pkg::*;
(
  input  logic       a,
  input  logic       p,
  input  logic       s,
  input  logic       c,
  output stage_res_t res
);

  logic cin_k;
  logic b_k;

  always_comb begin
    cin_k   = p ^ s;
    b_k     = a ^ p;
    res     = '0;
    res.b   = b_k;
    res.cin = cin_k;
`ifdef REV_ADDER_ANC_CHECK_EN
    // Undo the carry Peres gate, then the generate Peres gate; a clean line is 0.
    res.anc = (c ^ (p & cin_k)) ^ (a & b_k);
`else
    res.anc = 1'b0;
`endif
  end

endmodule

// File: rtl/reversible_adder_uncompute.sv
// Bit-serial, MSB-first uncompute of a reversible ripple adder; recovers b and cin.
// anc_err is live only when REV_ADDER_ANC_CHECK_EN is defined, otherwise held 0.
module reversible_adder_uncompute
  import rev_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_cin,
  output logic [WIDTH-1:0] anc_err,
  output logic             busy
);

  localparam int unsigned IW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] anc_q, anc_d;
  logic             c_q, c_d;
  logic             cin_q, cin_d;
  logic [IW-1:0]    k_q, k_d;
  stage_res_t       res;

  reversible_full_adder_inv u_stage (
    .a   (a_q[k_q]),
    .p   (p_q[k_q]),
    .s   (s_q[k_q]),
    .c   (c_q),
    .res (res)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    s_d     = s_q;
    b_d     = b_q;
    anc_d   = anc_q;
    c_d     = c_q;
    cin_d   = cin_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          p_d     = in_p;
          s_d     = in_s;
          c_d     = in_cout;
          b_d     = '0;
          anc_d   = '0;
          k_d     = IW'(WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        b_d[k_q]   = res.b;
        anc_d[k_q] = res.anc;
        c_d        = res.cin;
        if (k_q == '0) begin
          cin_d   = res.cin;
          state_d = DONE;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      b_q     <= '0;
      anc_q   <= '0;
      c_q     <= 1'b0;
      cin_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      s_q     <= s_d;
      b_q     <= b_d;
      anc_q   <= anc_d;
      c_q     <= c_d;
      cin_q   <= cin_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_cin   = cin_q;
  assign anc_err   = anc_q;

endmodule

// File: tb/tb_reversible_adder_uncompute.sv
// Directed and forward-model checks of reversible_adder_uncompute at WIDTH 4, 1 and 8.
module tb_reversible_adder_uncompute;

  logic       clk;
  logic       rst_n;
  logic       iv   [3];
  logic       ordy [3];
  logic [7:0] ia   [3];
  logic [7:0] ip   [3];
  logic [7:0] isum [3];
  logic       ic   [3];

  logic       irdy [3];
  logic       ov   [3];
  logic       bz   [3];
  logic       oc   [3];
  logic [7:0] oa   [3];
  logic [7:0] ob   [3];
  logic [7:0] ae   [3];

  logic       ir4, ov4, oc4, bz4;
  logic [3:0] oa4, ob4, ae4;
  logic       ir1, ov1, oc1, bz1;
  logic [0:0] oa1, ob1, ae1;
  logic       ir8, ov8, oc8, bz8;
  logic [7:0] oa8, ob8, ae8;

  int unsigned n_chk;
  int unsigned n_pass;
  int          wid [3];

  reversible_adder_uncompute #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir4),
    .in_a(ia[0][3:0]), .in_p(ip[0][3:0]), .in_s(isum[0][3:0]), .in_cout(ic[0]),
    .out_valid(ov4), .out_ready(ordy[0]), .out_a(oa4), .out_b(ob4),
    .out_cin(oc4), .anc_err(ae4), .busy(bz4)
  );

  reversible_adder_uncompute #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
    .in_a(ia[1][0:0]), .in_p(ip[1][0:0]), .in_s(isum[1][0:0]), .in_cout(ic[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_a(oa1), .out_b(ob1),
    .out_cin(oc1), .anc_err(ae1), .busy(bz1)
  );

  reversible_adder_uncompute #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir8),
    .in_a(ia[2]), .in_p(ip[2]), .in_s(isum[2]), .in_cout(ic[2]),
    .out_valid(ov8), .out_ready(ordy[2]), .out_a(oa8), .out_b(ob8),
    .out_cin(oc8), .anc_err(ae8), .busy(bz8)
  );

  always_comb begin
    irdy[0] = ir4; ov[0] = ov4; bz[0] = bz4; oc[0] = oc4;
    oa[0] = 8'(oa4); ob[0] = 8'(ob4); ae[0] = 8'(ae4);
    irdy[1] = ir1; ov[1] = ov1; bz[1] = bz1; oc[1] = oc1;
    oa[1] = 8'(oa1); ob[1] = 8'(ob1); ae[1] = 8'(ae1);
    irdy[2] = ir8; ov[2] = ov8; bz[2] = bz8; oc[2] = oc8;
    oa[2] = oa8; ob[2] = ob8; ae[2] = ae8;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Forward reversible ripple addition: reference lines from a, b, cin.
  task automatic fwd(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin,
                     output logic [7:0] p, output logic [7:0] s, output logic cout);
    logic [8:0] sum;
    logic [7:0] mask;
    mask = 8'((9'd1 << w) - 9'd1);
    sum  = {1'b0, a & mask} + {1'b0, b & mask} + {8'd0, cin};
    p    = (a ^ b) & mask;
    s    = sum[7:0] & mask;
    cout = sum[w];
  endtask

  task automatic drive_in(input int u, input logic [7:0] a, input logic [7:0] p,
                          input logic [7:0] s, input logic cout);
    ia[u] = a; ip[u] = p; isum[u] = s; ic[u] = cout; iv[u] = 1'b1;
  endtask

  // Accept one record on unit u, wait for the result, return it and hand it off.
  task automatic run_rec(input int u, input logic [7:0] a, input logic [7:0] p,
                         input logic [7:0] s, input logic cout,
                         output logic [7:0] b, output logic cin, output logic [7:0] anc,
                         output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!irdy[u] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!irdy[u]) check("in_ready_timeout", 32'(irdy[u]), 32'd1);
    drive_in(u, a, p, s, cout);
    @(posedge clk);
    #1 iv[u] = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!ov[u]) check("out_valid_timeout", 32'(ov[u]), 32'd1);
    b = ob[u]; cin = oc[u]; anc = ae[u];
    check("out_a", 32'(oa[u]), 32'(a));
    @(negedge clk);
    ordy[u] = 1'b1;
    @(posedge clk);
    #1 ordy[u] = 1'b0;
    check("valid_drop", 32'(ov[u]), 32'd0);
  endtask

  logic [7:0] rb, ranc, ra, rbb, rp, rs;
  logic       rcin, rc, rco;
  int         rlat;
  logic [7:0] exp_corrupt;

  initial begin
    n_chk = 0; n_pass = 0;
    wid[0] = 4; wid[1] = 1; wid[2] = 8;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; ia[i] = '0; ip[i] = '0; isum[i] = '0; ic[i] = 1'b0;
    end
`ifdef REV_ADDER_ANC_CHECK_EN
    exp_corrupt = 8'h08;
`else
    exp_corrupt = 8'h00;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 32'(irdy[i]), 32'd1);
      check("rst_out_valid", 32'(ov[i]), 32'd0);
      check("rst_busy", 32'(bz[i]), 32'd0);
      check("rst_outs", {oa[i], ob[i], ae[i], 7'd0, oc[i]}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // W=4 directed vectors
    run_rec(0, 8'h5, 8'h6, 8'h8, 1'b0, rb, rcin, ranc, rlat);
    check("v1_b", 32'(rb), 32'h3);
    check("v1_cin", 32'(rcin), 32'd0);
    check("v1_anc", 32'(ranc), 32'd0);
    check("v1_latency", 32'(rlat), 32'd4);

    run_rec(0, 8'hF, 8'hE, 8'h1, 1'b1, rb, rcin, ranc, rlat);
    check("v2_b", 32'(rb), 32'h1);
    check("v2_cin", 32'(rcin), 32'd1);
    check("v2_anc", 32'(ranc), 32'd0);

    run_rec(0, 8'h5, 8'h6, 8'h8, 1'b1, rb, rcin, ranc, rlat);
    check("corrupt_b", 32'(rb), 32'h3);
    check("corrupt_anc", 32'(ranc), 32'(exp_corrupt));

    // Backpressure: result held five cycles, in_valid asserted throughout
    @(negedge clk);
    drive_in(0, 8'h5, 8'h6, 8'h8, 1'b0);
    @(posedge clk);
    #1 check("bp_busy", 32'(bz[0]), 32'd1);
    for (int i = 0; i < 4 && !ov[0]; i++) @(posedge clk);
    #1 check("bp_valid", 32'(ov[0]), 32'd1);
    drive_in(0, 8'hA, 8'h3, 8'h7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(ov[0]), 32'd1);
      check("bp_hold_ready", 32'(irdy[0]), 32'd0);
      check("bp_hold_data", {16'd0, oa[0], ob[0]}, 32'h0503);
      check("bp_hold_cin", 32'(oc[0]), 32'd0);
    end
    ordy[0] = 1'b1; iv[0] = 1'b0;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    check("bp_after_valid", 32'(ov[0]), 32'd0);
    check("bp_after_ready", 32'(irdy[0]), 32'd1);

    // Reset in the middle of a W=8 run
    @(negedge clk);
    drive_in(2, 8'h3C, 8'h5A, 8'h77, 1'b1);
    @(posedge clk);
    #1 iv[2] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("mid_rst_ready", 32'(irdy[2]), 32'd1);
      check("mid_rst_valid", 32'(ov[2]), 32'd0);
      check("mid_rst_busy", 32'(bz[2]), 32'd0);
      check("mid_rst_outs", {oa[2], ob[2], ae[2], 7'd0, oc[2]}, 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    fwd(8, 8'hA7, 8'h6D, 1'b1, rp, rs, rco);
    run_rec(2, 8'hA7, rp, rs, rco, rb, rcin, ranc, rlat);
    check("post_rst_b", 32'(rb), 32'h6D);
    check("post_rst_cin", 32'(rcin), 32'd1);
    check("post_rst_latency", 32'(rlat), 32'd8);

    // Random operands at W=1 and W=8 through the forward model
    for (int u = 1; u < 3; u++) begin
      for (int t = 0; t < 16; t++) begin
        ra  = 8'($urandom);
        rbb = 8'($urandom);
        rc  = 1'($urandom);
        if (wid[u] == 1) begin ra = ra & 8'h1; rbb = rbb & 8'h1; end
        fwd(wid[u], ra, rbb, rc, rp, rs, rco);
        run_rec(u, ra, rp, rs, rco, rb, rcin, ranc, rlat);
        check("rand_b", 32'(rb), 32'(rbb));
        check("rand_cin", 32'(rcin), 32'(rc));
        check("rand_anc", 32'(ranc), 32'd0);
        check("rand_latency", 32'(rlat), 32'(wid[u]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reversible_adder_uncompute.md
# reversible_adder_uncompute

Bit-serial uncomputation engine for the Peres-gate ripple adder. It takes the full line state left behind by a WIDTH-bit reversible ripple addition (operand-a lines, propagate lines, sum lines and final carry) and runs the inverse Peres-gate pair stage by stage, MSB first. It recovers operand b and carry-in, and confirms that every ancilla returned to zero. It sits behind the reversible adder datapath and lets higher-level reversible synthesis release garbage lines for reuse.

## Interface
- WIDTH, 8, adder width in bits; minimum 1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input record valid.
- in_ready  out  1  engine idle and able to accept a record.
- in_a  in  WIDTH  preserved operand-a lines (g_a of each stage).
- in_p  in  WIDTH  propagate lines, p[i] = a[i]^b[i].
- in_s  in  WIDTH  sum lines.
- in_cout  in  1  final carry-out line of the MSB stage.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts the result.
- out_a  out  WIDTH  operand a passed through.
- out_b  out  WIDTH  recovered operand b.
- out_cin  out  1  recovered carry-in.
- anc_err  out  WIDTH  bit i set when the ancilla of stage i recovered non-zero.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_p/in_s, load carry register c=in_cout, clear out_b/anc_err, set bit index k=WIDTH-1, go to RUN.
- RUN: one stage per cycle, with a=in_a[k], p=in_p[k], s=in_s[k]:
  - cin_k = p^s
  - r = c^(p&cin_k)
  - b_k = a^p
  - anc_k = r^(a&b_k)
  - Write out_b[k]=b_k and anc_err[k]=anc_k, then set c=cin_k.
  - At k=0, go to DONE and set out_cin=cin_0. Otherwise decrement k.
- DONE: out_valid=1 and all outputs held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Input ports are not sampled after acceptance.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset asserted mid-operation: immediate return to IDLE. In-flight record is discarded and no partial result is presented.
- Reset values: in_ready=1, out_valid=0, busy=0, out_a=0, out_b=0, out_cin=0, anc_err=0.

## Timing
- Acceptance edge T. Stage k=WIDTH-1 is processed at edge T+1, and stage 0 at edge T+WIDTH.
- out_valid is high from T+WIDTH until the edge where out_ready is sampled high.
- in_ready returns one cycle after the output transfer; there is no same-cycle bypass.
- Minimum spacing between acceptances: WIDTH+2 cycles with out_ready held high.
- out_ready high before out_valid has no effect.
- All outputs are registered; there is no combinational in-to-out path.

## Configuration
- REV_ADDER_ANC_CHECK_EN defined: anc_err is computed per stage as above.
- Not defined: the anc_k logic is removed and anc_err is held 0. All other behaviour and timing are unchanged.

## Structure
- Package rev_adder_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the index-width function clog2(WIDTH), floored at 1;
  - the per-stage result struct {b, cin, anc}.
- Sub-module reversible_full_adder_inv is a combinational inverse of one adder stage. It maps (a, p, s, c) to (b, cin, anc) and is instantiated once in the top-level datapath.

## Test plan
- Reset during RUN (k mid-range): in_ready=1, out_valid=0, busy=0 and all outputs 0 while reset is held. A fresh record accepted after reset completes normally.
- WIDTH=4, in_a=0x5, in_p=0x6, in_s=0x8, in_cout=0: out_b=0x3, out_cin=0, anc_err=0. out_valid rises 4 cycles after acceptance.
- WIDTH=4, in_a=0xF, in_p=0xE, in_s=0x1, in_cout=1: out_b=0x1, out_cin=1, anc_err=0.
- Corrupted carry (WIDTH=4, in_a=0x5, in_p=0x6, in_s=0x8, in_cout=1): anc_err[3]=1 with the macro defined, and anc_err=0 without it.
- Backpressure (out_ready low 5 cycles in DONE, in_valid held high): outputs stable and in_ready=0 throughout. After out_ready is sampled, in_ready rises the next cycle.
- Random a/b/cin at WIDTH=1 and WIDTH=8, with forward reference lines generated by the bench: recovered b and cin match, anc_err=0, no dropped or duplicated transfers.
